// File: rtl/sub_pkg.sv
// Shared definitions for the digit-serial subtractor: FSM encoding and default sizes.
package sub_pkg;

    localparam int SUB_WIDTH   = 32;
    localparam int SUB_DIGIT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Signed overflow of a difference, judged from the operand and result sign bits.
    function automatic logic sub_overflow(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

endpackage

// File: rtl/sub_digit.sv
// One DIGIT_W-bit subtraction slice in carry form: d = a + ~b + ~bin, bout = ~carry.
module sub_digit
    import sub_pkg::*;
#(
    parameter int DIGIT_W = SUB_DIGIT_W
) (
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               bin,
    output logic [DIGIT_W-1:0] d,
    output logic               bout
);

    logic [DIGIT_W:0] sum_s;

    assign sum_s = {1'b0, a} + {1'b0, ~b} + {{DIGIT_W{1'b0}}, ~bin};
    assign d     = sum_s[DIGIT_W-1:0];
    assign bout  = ~sum_s[DIGIT_W];

endmodule

// File: rtl/serial_subtractor32.sv
// Digit-serial subtractor D = A - B - Bin, LS digit first, valid/ready on both sides.
// Optional signed-overflow output V is built when SUB_OVERFLOW_EN is defined.
module serial_subtractor32
    import sub_pkg::*;
#(
    parameter int WIDTH   = SUB_WIDTH,
    parameter int DIGIT_W = SUB_DIGIT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             Bout
`ifdef SUB_OVERFLOW_EN
    ,
    output logic             V
`endif
);

    localparam int NDIG  = WIDTH / DIGIT_W;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    generate
        if ((WIDTH % DIGIT_W) != 0) begin : g_bad_digit
            $error("serial_subtractor32: WIDTH must be a multiple of DIGIT_W");
        end
    endgenerate

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, b_q, d_q;
    logic               borrow_q;
    logic               bout_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic               accept_s;
    logic               last_s;
    logic [DIGIT_W-1:0] dig_s;
    logic               dig_bout_s;
    logic [WIDTH-1:0]   dig_ext_s;
    logic [WIDTH-1:0]   d_shift_s;

    assign accept_s  = in_valid && in_ready_q;
    assign last_s    = (cnt_q == CNT_W'(NDIG - 1));
    assign dig_ext_s = WIDTH'(dig_s);
    // Result digits enter at the MSB end so the first digit ends up at bit 0.
    assign d_shift_s = (d_q >> DIGIT_W) | (dig_ext_s << (WIDTH - DIGIT_W));

    sub_digit #(
        .DIGIT_W (DIGIT_W)
    ) u_digit (
        .a    (a_q[DIGIT_W-1:0]),
        .b    (b_q[DIGIT_W-1:0]),
        .bin  (borrow_q),
        .d    (dig_s),
        .bout (dig_bout_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the unused encoding falls back to IDLE.
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_CALC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (last_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_CALC;
                end
            end
            ST_DONE: begin
                if (out_valid_q && out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs follow the upcoming state so they come straight from flops.
    always_comb begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        if (state_d == ST_IDLE) begin
            in_ready_d = 1'b1;
        end else begin
            in_ready_d = 1'b0;
        end
        if (state_d == ST_DONE) begin
            out_valid_d = 1'b1;
        end else begin
            out_valid_d = 1'b0;
        end
    end

    // Operand shift registers, borrow chain, digit counter and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            d_q         <= '0;
            borrow_q    <= 1'b0;
            bout_q      <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        a_q      <= A;
                        b_q      <= B;
                        borrow_q <= Bin;
                        cnt_q    <= '0;
                    end
                end
                ST_CALC: begin
                    a_q      <= a_q >> DIGIT_W;
                    b_q      <= b_q >> DIGIT_W;
                    d_q      <= d_shift_s;
                    borrow_q <= dig_bout_s;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (last_s) begin
                        bout_q <= dig_bout_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SUB_OVERFLOW_EN
    logic v_q;

    // On the last digit the low slices of a_q/b_q hold the operand sign bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= 1'b0;
        end else if ((state_q == ST_CALC) && last_s) begin
            v_q <= sub_overflow(a_q[DIGIT_W-1], b_q[DIGIT_W-1], dig_s[DIGIT_W-1]);
        end else begin
            v_q <= v_q;
        end
    end

    assign V = v_q;
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign D         = d_q;
    assign Bout      = bout_q;

endmodule

// File: tb/tb_serial_subtractor32.sv
// Self-checking bench for serial_subtractor32: directed cases plus random vectors
// against an arithmetic reference model. Define SUB_OVERFLOW_EN to also check V.
module tb_serial_subtractor32;

    localparam int WIDTH = 32;
    localparam int NDIG  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] D;
    logic             Bout;
`ifdef SUB_OVERFLOW_EN
    logic             V;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_subtractor32 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .Bout      (Bout)
`ifdef SUB_OVERFLOW_EN
        ,
        .V         (V)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_d(input logic [31:0] a, input logic [31:0] b, input logic bin);
        logic [63:0] t;
        t = {32'd0, a} - {32'd0, b} - {63'd0, bin};
        return t[31:0];
    endfunction

    function automatic logic ref_bout(input logic [31:0] a, input logic [31:0] b, input logic bin);
        return ({32'd0, a} < ({32'd0, b} + {63'd0, bin}));
    endfunction

    function automatic logic ref_v(input logic [31:0] a, input logic [31:0] b, input logic bin);
        longint sa, sb, r;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        r  = sa - sb - longint'(bin);
        return (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    // One complete transaction; all sampling and driving happens on the falling edge.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic bin,
                          input int stall, input bit full);
        int t;
        int lat;
        logic [31:0] d_held;
        logic        bo_held;
        t = 0;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("in_ready_wait", in_ready, 1'b1);
        A = a; B = b; Bin = bin; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        A = $urandom; B = $urandom; Bin = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (full) chk("latency", 64'(lat), 64'(NDIG));
        chk("D", D, ref_d(a, b, bin));
        chk("Bout", Bout, ref_bout(a, b, bin));
        chk("recon", 32'(D + b + 32'(bin)), a);
`ifdef SUB_OVERFLOW_EN
        chk("V", V, ref_v(a, b, bin));
`endif
        if (full) chk("in_ready_busy", in_ready, 1'b0);
        d_held  = D;
        bo_held = Bout;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'($urandom);
            A = $urandom; B = $urandom; Bin = 1'($urandom);
            @(negedge clk);
            chk("stall_D", D, d_held);
            chk("stall_Bout", Bout, bo_held);
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_in_ready", in_ready, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        if (full) begin
            chk("drain_valid", out_valid, 1'b0);
            chk("drain_in_ready", in_ready, 1'b1);
        end
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rbin;
        int          t;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = 32'd0; B = 32'd0; Bin = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_D", D, 32'd0);
        chk("rst_Bout", Bout, 1'b0);
`ifdef SUB_OVERFLOW_EN
        chk("rst_V", V, 1'b0);
`endif

        run_op(32'd300, 32'd100, 1'b0, 0, 1'b1);
        run_op(32'd0, 32'd1, 1'b0, 0, 1'b1);
        run_op(32'd1488, 32'd228, 1'b1, 0, 1'b1);
        run_op(32'd1337, 32'd1337, 1'b1, 0, 1'b1);
        run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 0, 1'b1);
        run_op(32'h1234_5678, 32'h8765_4321, 1'b1, 10, 1'b1);
        run_op(32'd42, 32'd17, 1'b0, 0, 1'b1);
        run_op(32'h8000_0000, 32'd1, 1'b0, 0, 1'b1);
        run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 1'b1);

        // Reset in the middle of a calculation discards the partial result.
        A = 32'hDEAD_BEEF; B = 32'h0000_1111; Bin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_in_ready", in_ready, 1'b1);
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_D", D, 32'd0);
        chk("mid_rst_Bout", Bout, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("mid_rst_no_pulse", out_valid, 1'b0);
        end
        run_op(32'd6216144, 32'd135761, 1'b0, 0, 1'b1);

        for (int n = 0; n < 1000; n++) begin
            ra   = $urandom;
            rb   = (n % 8 == 0) ? ra : 32'($urandom);
            rbin = 1'($urandom);
            t    = (n % 50 == 0) ? 3 : 0;
            run_op(ra, rb, rbin, t, (n % 100 == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
